// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the byte-merge helper for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} dcache_state_t;

  localparam int SETS_DEF   = 16;
  localparam int WORDS_DEF  = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int OFF_W      = $clog2(WORDS_DEF) + 2;
  localparam int IDX_W      = $clog2(SETS_DEF);
  localparam int TAG_W      = ADDR_W_DEF - OFF_W - IDX_W;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// CPU-side request port and backing-memory port of the data cache, bundled as one interface.
interface dcache_dm_if #(parameter int ADDR_W = 32);
  logic              Req;
  logic              WE;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WD;
  logic [3:0]        ByteEn;
  logic              Stall;
  logic [31:0]       RDWord;
  logic              MemReq;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWD;
  logic [3:0]        MemBE;
  logic              MemAck;
  logic [31:0]       MemRD;

  modport slave (
    input  Req, WE, Addr, WD, ByteEn, MemAck, MemRD,
    output Stall, RDWord, MemReq, MemWE, MemAddr, MemWD, MemBE
  );

  modport master (
    output Req, WE, Addr, WD, ByteEn, MemAck, MemRD,
    input  Stall, RDWord, MemReq, MemWE, MemAddr, MemWD, MemBE
  );
endinterface

// File: rtl/dcache_store_array.sv
// Valid/tag/data flop arrays: combinational read of one line, clocked fill, tag and byte-merge writes.
module dcache_store_array
  import dcache_pkg::*;
#(
  parameter int SETS  = SETS_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int TAG_B = TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(SETS)-1:0]  idx,
  input  logic [$clog2(WORDS)-1:0] rd_word,
  input  logic [$clog2(WORDS)-1:0] wr_word,
  input  logic                     inv_en,
  input  logic                     fill_en,
  input  logic                     tag_en,
  input  logic                     merge_en,
  input  logic [TAG_B-1:0]         tag_in,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  output logic                     rd_valid,
  output logic [TAG_B-1:0]         rd_tag,
  output logic [31:0]              rd_data
);
  localparam int IDX_B = $clog2(SETS);

  logic              valid_reg [SETS];
  logic [TAG_B-1:0]  tag_mem   [SETS];
  logic [31:0]       data_mem  [SETS][WORDS];

  // Only the valid bits are reset; tag/data contents are meaningless until a line is valid.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
      end else if (idx == IDX_B'(gi)) begin
        if (inv_en)      valid_reg[gi] <= 1'b0;
        else if (tag_en) valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_en) tag_mem[idx] <= tag_in;
    if (fill_en)       data_mem[idx][wr_word] <= wdata;
    else if (merge_en) data_mem[idx][wr_word] <= merge_bytes(data_mem[idx][wr_word], wdata, be);
  end

  assign rd_valid = valid_reg[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx][rd_word];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a request/ack backing-memory port.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int SETS   = SETS_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dcache_dm_if.slave bus
);
  localparam int WRD_B = $clog2(WORDS);
  localparam int IDX_B = $clog2(SETS);
  localparam int OFF_B = WRD_B + 2;
  localparam int TAG_B = ADDR_W - OFF_B - IDX_B;
  localparam logic [WRD_B-1:0] LAST_BEAT = WRD_B'(WORDS - 1);

  dcache_state_t     state_reg, state_next;
  logic [ADDR_W-1:2] addr_reg;
  logic [31:0]       wd_reg;
  logic [3:0]        be_reg;
  logic [WRD_B-1:0]  beat_reg, beat_next;

  logic              latch_en, inv_en, fill_en, tag_en, merge_en, stall;
  logic [31:0]       rdword;
  logic [IDX_B-1:0]  arr_idx;
  logic [WRD_B-1:0]  rd_word, wr_word;
  logic              rd_valid, hit;
  logic [TAG_B-1:0]  rd_tag;
  logic [31:0]       rd_data, arr_wdata;

  // IDLE looks up the live CPU address; every other state works on the latched one.
  assign arr_idx   = (state_reg == IDLE) ? bus.Addr[OFF_B+IDX_B-1:OFF_B] : addr_reg[OFF_B+IDX_B-1:OFF_B];
  assign rd_word   = (state_reg == IDLE) ? bus.Addr[OFF_B-1:2] : addr_reg[OFF_B-1:2];
  assign wr_word   = (state_reg == REFILL) ? beat_reg : bus.Addr[OFF_B-1:2];
  assign arr_wdata = (state_reg == REFILL) ? bus.MemRD : bus.WD;
  assign hit       = rd_valid && (rd_tag == bus.Addr[ADDR_W-1:OFF_B+IDX_B]);

  dcache_store_array #(.SETS(SETS), .WORDS(WORDS), .TAG_B(TAG_B)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (arr_idx),
    .rd_word  (rd_word),
    .wr_word  (wr_word),
    .inv_en   (inv_en),
    .fill_en  (fill_en),
    .tag_en   (tag_en),
    .merge_en (merge_en),
    .tag_in   (addr_reg[ADDR_W-1:OFF_B+IDX_B]),
    .wdata    (arr_wdata),
    .be       (bus.ByteEn),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (latch_en) begin
        addr_reg <= bus.Addr[ADDR_W-1:2];
        wd_reg   <= bus.WD;
        be_reg   <= bus.ByteEn;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    latch_en   = 1'b0;
    inv_en     = 1'b0;
    fill_en    = 1'b0;
    tag_en     = 1'b0;
    merge_en   = 1'b0;
    stall      = 1'b0;
    rdword     = '0;
    case (state_reg)
      IDLE: begin
        if (bus.Req) begin
          if (bus.WE) begin
            stall      = 1'b1;
            latch_en   = 1'b1;
            merge_en   = hit;
            state_next = WRITE;
          end else if (!hit) begin
            // Drop the line now so an interrupted refill can never leave it marked valid.
            stall      = 1'b1;
            latch_en   = 1'b1;
            inv_en     = 1'b1;
            beat_next  = '0;
            state_next = REFILL;
          end else begin
            rdword = rd_data;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (bus.MemAck) begin
          fill_en   = 1'b1;
          beat_next = beat_reg + WRD_B'(1);
          if (beat_reg == LAST_BEAT) begin
            tag_en     = 1'b1;
            state_next = RESPOND;
          end
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (bus.MemAck) state_next = RESPOND;
      end
      RESPOND: begin
        if (bus.Req && !bus.WE) rdword = rd_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs depend on state and latched values only, never on MemAck.
  always_comb begin
    bus.MemReq  = 1'b0;
    bus.MemWE   = 1'b0;
    bus.MemAddr = '0;
    bus.MemWD   = '0;
    bus.MemBE   = '0;
    case (state_reg)
      REFILL: begin
        bus.MemReq  = 1'b1;
        bus.MemBE   = 4'hF;
        bus.MemAddr = {addr_reg[ADDR_W-1:OFF_B], beat_reg, 2'b00};
      end
      WRITE: begin
        bus.MemReq  = 1'b1;
        bus.MemWE   = 1'b1;
        bus.MemAddr = {addr_reg, 2'b00};
        bus.MemWD   = wd_reg;
        bus.MemBE   = be_reg;
      end
      default: ;
    endcase
  end

  assign bus.Stall  = stall & rst_n;
  assign bus.RDWord = rdword;

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed scenarios plus random loads/stores against a memory-level cache model.
module tb_dcache_dm;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_delay = 2;
  int   ack_cnt   = 0;

  always #5 clk = ~clk;

  dcache_dm_if #(.ADDR_W(32)) bus ();
  dcache_dm #(.SETS(16), .WORDS(4), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // resp_mem is what the responder really holds; ref_mem is what the bench expects memory to hold.
  logic [31:0] resp_mem [bit [29:0]];
  logic [31:0] ref_mem  [bit [29:0]];
  bit          ref_valid [16];
  logic [23:0] ref_tag   [16];

  logic [31:0] log_addr[$];
  bit          log_we[$];
  logic [31:0] log_wd[$];
  logic [3:0]  log_be[$];

  function automatic logic [31:0] init_word(logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] ref_word(logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] resp_word(logic [29:0] wa);
    return resp_mem.exists(wa) ? resp_mem[wa] : init_word(wa);
  endfunction

  // Backing memory: acks after ack_delay idle cycles per beat, logs every accepted beat.
  initial begin
    bus.MemAck = 1'b0;
    bus.MemRD  = '0;
    forever begin
      @(negedge clk);
      if (bus.MemReq === 1'b1) begin
        ack_cnt++;
        if (ack_cnt > ack_delay) begin
          ack_cnt = 0;
          bus.MemAck = 1'b1;
          log_addr.push_back(bus.MemAddr);
          log_we.push_back(bus.MemWE);
          log_wd.push_back(bus.MemWD);
          log_be.push_back(bus.MemBE);
          if (bus.MemWE) begin
            resp_mem[bus.MemAddr[31:2]] = be_merge(resp_word(bus.MemAddr[31:2]), bus.MemWD, bus.MemBE);
            bus.MemRD = '0;
          end else begin
            bus.MemRD = resp_word(bus.MemAddr[31:2]);
          end
        end else begin
          bus.MemAck = 1'b0;
          bus.MemRD  = 32'hDEAD_BEEF;
        end
      end else begin
        ack_cnt    = 0;
        bus.MemAck = 1'b0;
      end
    end
  end

  task automatic log_clear();
    log_addr.delete(); log_we.delete(); log_wd.delete(); log_be.delete();
  endtask

  // Cache model at the level of "which line each set holds"; data always equals memory (write-through).
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] exp_rd, output int exp_cyc, output int exp_beats);
    int idx;
    bit hit;
    idx = int'(a[7:4]);
    hit = ref_valid[idx] && (ref_tag[idx] == a[31:8]);
    if (we) begin
      ref_mem[a[31:2]] = be_merge(ref_word(a[31:2]), wd, be);
      exp_rd    = '0;
      exp_beats = 1;
      exp_cyc   = 2 + ack_delay;
    end else begin
      exp_rd = ref_word(a[31:2]);
      if (hit) begin
        exp_beats = 0;
        exp_cyc   = 0;
      end else begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a[31:8];
        exp_beats = 4;
        exp_cyc   = 1 + 4 * (ack_delay + 1);
      end
    end
  endtask

  // Issues one request, counts stalled cycles, samples RDWord in the completing cycle.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output int cyc);
    log_clear();
    @(negedge clk);
    bus.Req = 1'b1; bus.WE = we; bus.Addr = a; bus.WD = wd; bus.ByteEn = be;
    #1;
    cyc = 0;
    while (bus.Stall !== 1'b0 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    rd = bus.RDWord;
    @(posedge clk); #1;
    bus.Req = 1'b0; bus.WE = 1'b0; bus.Addr = $urandom; bus.WD = $urandom; bus.ByteEn = 4'($urandom);
    $display("txn we=%0b addr=%08h wd=%08h be=%04b rd=%08h stall_cycles=%0d beats=%0d",
             we, a, wd, be, rd, cyc, log_addr.size());
  endtask

  task automatic test_reset();
    bus.Req = 1'b0; bus.WE = 1'b0; bus.Addr = '0; bus.WD = '0; bus.ByteEn = '0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.Stall); end
    n_vec++; if ({bus.MemReq, bus.MemWE, bus.MemBE} !== 6'b0) begin
      n_err++; $display("FAIL reset_memctl: got req=%b we=%b be=%b want 0", bus.MemReq, bus.MemWE, bus.MemBE); end
    n_vec++; if (bus.MemAddr !== 32'h0 || bus.MemWD !== 32'h0) begin
      n_err++; $display("FAIL reset_memdata: got addr=%h wd=%h want 0", bus.MemAddr, bus.MemWD); end
    n_vec++; if (bus.RDWord !== 32'h0) begin n_err++; $display("FAIL reset_rdword: got %h want 0", bus.RDWord); end
    bus.Req = 1'b1; bus.Addr = 32'h104;
    #1;
    n_vec++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_req: got %b want 0", bus.Stall); end
    bus.Req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_plan_load();
    logic [31:0] rd, exp_rd;
    int cyc, exp_cyc, exp_beats;
    ack_delay = 2;
    model(1'b0, 32'h104, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h104, '0, '0, rd, cyc);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL plan_load_rd: got %h want %h", rd, exp_rd); end
    n_vec++; if (cyc != exp_cyc) begin n_err++; $display("FAIL plan_load_stall: got %0d want %0d", cyc, exp_cyc); end
    n_vec++; if (log_addr.size() != exp_beats) begin
      n_err++; $display("FAIL plan_load_beats: got %0d want %0d", log_addr.size(), exp_beats);
    end else begin
      for (int i = 0; i < exp_beats; i++) begin
        n_vec++;
        if (log_addr[i] !== 32'(32'h100 + 4 * i) || log_we[i] !== 1'b0 || log_be[i] !== 4'hF) begin
          n_err++; $display("FAIL plan_load_beat%0d: got addr=%h we=%b be=%b want addr=%h we=0 be=1111",
                            i, log_addr[i], log_we[i], log_be[i], 32'(32'h100 + 4 * i));
        end
      end
    end
    model(1'b0, 32'h10C, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h10C, '0, '0, rd, cyc);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL plan_hit_rd: got %h want %h", rd, exp_rd); end
    n_vec++; if (cyc != 0 || log_addr.size() != exp_beats) begin
      n_err++; $display("FAIL plan_hit_stall: got cycles=%0d beats=%0d want 0/%0d", cyc, log_addr.size(), exp_beats); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd, exp_rd;
    int cyc, exp_cyc, exp_beats;
    ack_delay = 1;
    model(1'b1, 32'h108, 32'hAABB_CCDD, 4'b0011, exp_rd, exp_cyc, exp_beats);
    access(1'b1, 32'h108, 32'hAABB_CCDD, 4'b0011, rd, cyc);
    n_vec++; if (cyc != exp_cyc || rd !== exp_rd) begin
      n_err++; $display("FAIL store_hit_resp: got cycles=%0d rd=%h want %0d/%h", cyc, rd, exp_cyc, exp_rd); end
    n_vec++;
    if (log_addr.size() != exp_beats || log_addr[0] !== 32'h108 || log_we[0] !== 1'b1 ||
        log_be[0] !== 4'b0011 || log_wd[0] !== 32'hAABB_CCDD) begin
      n_err++; $display("FAIL store_hit_beat: got n=%0d addr=%h we=%b be=%b wd=%h want 1/108/1/0011/aabbccdd",
                        log_addr.size(), log_addr[0], log_we[0], log_be[0], log_wd[0]);
    end
    model(1'b0, 32'h108, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h108, '0, '0, rd, cyc);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL store_hit_reload: got %h want %h", rd, exp_rd); end
    n_vec++; if (cyc != exp_cyc) begin n_err++; $display("FAIL store_hit_stays: got %0d want %0d", cyc, exp_cyc); end
  endtask

  task automatic test_store_miss();
    logic [31:0] rd, exp_rd, wd;
    int cyc, exp_cyc, exp_beats;
    ack_delay = 2;
    wd = $urandom;
    model(1'b1, 32'h2000, wd, 4'hF, exp_rd, exp_cyc, exp_beats);
    access(1'b1, 32'h2000, wd, 4'hF, rd, cyc);
    n_vec++; if (log_addr.size() != exp_beats || log_we[0] !== 1'b1 || log_addr[0] !== 32'h2000) begin
      n_err++; $display("FAIL store_miss_beat: got n=%0d we=%b addr=%h want %0d/1/2000",
                        log_addr.size(), log_we[0], log_addr[0], exp_beats); end
    n_vec++; if (cyc != exp_cyc) begin n_err++; $display("FAIL store_miss_stall: got %0d want %0d", cyc, exp_cyc); end
    model(1'b0, 32'h2000, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h2000, '0, '0, rd, cyc);
    n_vec++; if (log_addr.size() != exp_beats || cyc != exp_cyc) begin
      n_err++; $display("FAIL store_miss_noalloc: got beats=%0d cycles=%0d want %0d/%0d",
                        log_addr.size(), cyc, exp_beats, exp_cyc); end
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL store_miss_data: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    logic [31:0] rd, exp_rd;
    int cyc, exp_cyc, exp_beats;
    seq[0] = 32'h104; seq[1] = 32'h1104; seq[2] = 32'h104;
    ack_delay = 1;
    for (int k = 0; k < 3; k++) begin
      model(1'b0, seq[k], '0, '0, exp_rd, exp_cyc, exp_beats);
      access(1'b0, seq[k], '0, '0, rd, cyc);
      n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL conflict_rd%0d: got %h want %h", k, rd, exp_rd); end
      n_vec++; if (log_addr.size() != 4 || exp_beats != 4 || log_addr[0] !== (seq[k] & 32'hFFFF_FFF0)) begin
        n_err++; $display("FAIL conflict_refill%0d: got beats=%0d first=%h want 4/%h",
                          k, log_addr.size(), log_addr[0], seq[k] & 32'hFFFF_FFF0); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, exp_rd;
    int cyc, exp_cyc, exp_beats, w;
    ack_delay = 2;
    log_clear();
    @(negedge clk);
    bus.Req = 1'b1; bus.WE = 1'b0; bus.Addr = 32'h1234;
    w = 0;
    while (log_addr.size() < 2 && w < 100) begin @(negedge clk); #1; w++; end
    @(negedge clk); #1;
    n_vec++; if (bus.MemAddr !== 32'h1238 || bus.MemReq !== 1'b1) begin
      n_err++; $display("FAIL abort_beat2: got req=%b addr=%h want 1/1238", bus.MemReq, bus.MemAddr); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.MemReq !== 1'b0 || bus.Stall !== 1'b0) begin
      n_err++; $display("FAIL abort_reset_out: got req=%b stall=%b want 0/0", bus.MemReq, bus.Stall); end
    n_vec++; if (bus.MemAddr !== 32'h0 || bus.RDWord !== 32'h0) begin
      n_err++; $display("FAIL abort_reset_data: got addr=%h rd=%h want 0/0", bus.MemAddr, bus.RDWord); end
    @(negedge clk);
    bus.Req = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    model(1'b0, 32'h1234, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h1234, '0, '0, rd, cyc);
    n_vec++; if (log_addr.size() != exp_beats || log_addr[0] !== 32'h1230) begin
      n_err++; $display("FAIL abort_restart: got beats=%0d first=%h want %0d/1230",
                        log_addr.size(), log_addr[0], exp_beats); end
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL abort_data: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_ack_held();
    logic [31:0] rd, exp_rd;
    int cyc, exp_cyc, exp_beats;
    ack_delay = 0;
    model(1'b0, 32'h5F0, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h5F0, '0, '0, rd, cyc);
    n_vec++; if (cyc != 5) begin n_err++; $display("FAIL held_stall: got %0d want 5", cyc); end
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL held_rd: got %h want %h", rd, exp_rd); end
    @(negedge clk); #1;
    n_vec++; if (bus.MemReq !== 1'b0 || log_addr.size() != exp_beats) begin
      n_err++; $display("FAIL held_extra_beat: got req=%b beats=%0d want 0/%0d", bus.MemReq, log_addr.size(), exp_beats); end
    model(1'b0, 32'h5F4, '0, '0, exp_rd, exp_cyc, exp_beats);
    access(1'b0, 32'h5F4, '0, '0, rd, cyc);
    n_vec++; if (rd !== exp_rd || cyc != 0) begin
      n_err++; $display("FAIL held_then_hit: got rd=%h cycles=%0d want %h/0", rd, cyc, exp_rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp_rd, exp_addr;
    logic [3:0]  be;
    bit          we;
    int          cyc, exp_cyc, exp_beats;
    for (int t = 0; t < 80; t++) begin
      we = ($urandom_range(0, 9) < 3);
      a  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
      wd = $urandom;
      be = 4'($urandom);
      ack_delay = $urandom_range(0, 3);
      model(we, a, wd, be, exp_rd, exp_cyc, exp_beats);
      access(we, a, wd, be, rd, cyc);
      n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rand%0d_rd: got %h want %h", t, rd, exp_rd); end
      n_vec++; if (cyc != exp_cyc) begin n_err++; $display("FAIL rand%0d_stall: got %0d want %0d", t, cyc, exp_cyc); end
      n_vec++;
      if (log_addr.size() != exp_beats) begin
        n_err++; $display("FAIL rand%0d_beats: got %0d want %0d", t, log_addr.size(), exp_beats);
      end else begin
        for (int i = 0; i < exp_beats; i++) begin
          exp_addr = we ? {a[31:2], 2'b00} : {a[31:4], 2'(i), 2'b00};
          n_vec++;
          if (log_addr[i] !== exp_addr || log_we[i] !== we || log_be[i] !== (we ? be : 4'hF) ||
              (we && log_wd[i] !== wd)) begin
            n_err++; $display("FAIL rand%0d_beat%0d: got addr=%h we=%b be=%b wd=%h want addr=%h we=%b",
                              t, i, log_addr[i], log_we[i], log_be[i], log_wd[i], exp_addr, we);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      resp_mem[30'h40 + 30'(i)] = 32'(32'h11 * (i + 1));
      ref_mem[30'h40 + 30'(i)]  = 32'(32'h11 * (i + 1));
    end
    test_reset();
    test_plan_load();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_abort();
    test_ack_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the execute-stage memory request and the load formatter.
- On loads it returns the full aligned 32-bit word. The downstream load formatter then applies byte/half selection from Addr[1:0] and sign/zero extension.
- Stalls the pipeline on misses and stores, and drives a simple request/acknowledge port to backing data memory.

Parameters:
- SETS, 16, number of lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Req  in  1  CPU access request; Addr/WE/WD/ByteEn held stable while Stall=1.
- WE  in  1  1 = store, 0 = load.
- Addr  in  ADDR_W  byte address; bits [1:0] ignored here.
- WD  in  32  store data, already lane-aligned.
- ByteEn  in  4  store byte lanes.
- Stall  out  1  freeze pipeline; request not complete.
- RDWord  out  32  aligned load word; valid when Req & !WE & !Stall.
- MemReq  out  1  backing-memory request.
- MemWE  out  1  backing write.
- MemAddr  out  ADDR_W  word-aligned backing address ([1:0]=0).
- MemWD  out  32  backing write data.
- MemBE  out  4  backing byte enables.
- MemAck  in  1  beat accepted / read data valid this cycle.
- MemRD  in  32  backing read data, valid with MemAck.

Behaviour:
- Address split, with OFF = log2(WORDS) + 2 and IDX = log2(SETS):
  - word = Addr[OFF-1:2]
  - index = Addr[OFF+IDX-1:OFF]
  - tag = Addr[ADDR_W-1:OFF+IDX]
  - Defaults: word [3:2], index [7:4], tag [31:8].
- Storage:
  - Per line: valid bit, tag and WORDS data words, held in flop arrays.
  - Reads are combinational. Writes occur on the clock edge.
- Reset (async, rst_n=0):
  - All valid bits are cleared.
  - State = IDLE.
  - MemReq, MemWE and Stall are 0. MemAddr, MemWD, MemBE and RDWord are 0.
  - Data and tag arrays are not reset.
- hit = valid[index] & (tag_arr[index] == tag).
- State IDLE:
  - No Req: Stall=0, stay in IDLE.
  - Req & !WE & hit: Stall=0, RDWord = data[index][word] in the same cycle (zero latency), stay in IDLE.
  - Req & !WE & !hit:
    - Stall=1 combinationally.
    - Latch Addr.
    - Invalidate the line, so that if rst_n is not asserted an aborted refill never leaves a stale valid line.
    - Go to REFILL with beat counter = 0.
  - Req & WE:
    - Stall=1.
    - Latch Addr, WD and ByteEn.
    - If hit, merge WD into data[index][word] per ByteEn on this edge.
    - Go to WRITE.
- State REFILL:
  - Stall=1, MemReq=1, MemWE=0, MemBE=4'hF.
  - MemAddr = {latched tag, index, beat, 2'b00}; beats run from word 0 to WORDS-1 (not critical-word-first).
  - On each MemAck, write MemRD to data[index][beat] and increment beat.
  - MemReq stays high across beats with no idle cycle.
  - On the ack of the last beat: set the tag and valid bit, then go to RESPOND.
- State WRITE:
  - Stall=1, MemReq=1, MemWE=1, MemAddr = latched word address, MemWD/MemBE = latched data/enables.
  - On MemAck, go to RESPOND.
- State RESPOND:
  - Stall=0; the request is consumed this cycle.
  - For a load, RDWord = data[index][word] (now a hit).
  - Next state is always IDLE.
  - Req observed in RESPOND is not re-issued. The pipeline advances on this edge, so the next request is evaluated in IDLE.
- MemAck rules:
  - MemAck is only sampled while MemReq=1; MemAck in IDLE or RESPOND is ignored.
  - MemAck held high for consecutive cycles counts as consecutive beats.
- Store miss: backing memory is written; the cache is unchanged (no allocate).
- A store to a line being refilled cannot occur, because the pipeline is stalled.
- RDWord is 0 whenever it is not valid, so the downstream formatter gets a deterministic value.
- Outputs MemReq, MemWE, MemAddr, MemWD and MemBE are registered or state-derived only; none combinationally depend on MemAck.

Decomposition:
- Shared package dcache_pkg:
  - state enum dcache_state_t {IDLE, REFILL, WRITE, RESPOND}.
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters.
  - function merge_bytes(old, wd, be) returning a 32-bit word.
- Sub-module dcache_store_array: valid/tag/data flop arrays with combinational read, line write and byte-merge write ports. The FSM and memory-port control stay in dcache_dm.

Test Plan:
- Reset then load 0x0000_0104 with memory words 0x100..0x10C = 11,22,33,44 and MemAck after 2 cycles per beat. Required:
  - Stall=1 through 4 beats at MemAddr 0x100, 0x104, 0x108, 0x10C.
  - RESPOND gives RDWord=0x22.
  - A following load of 0x10C hits with Stall=0 and RDWord=0x44.
- Store WD=0xAABBCCDD, ByteEn=4'b0011 to cached 0x108 (holding 0x33). Required:
  - MemWE=1, MemBE=0011, MemAddr=0x108.
  - After ack, a load of 0x108 hits and returns 0x0000CCDD.
- Store miss to 0x2000. Required: one write beat, then a load of 0x2000 misses and refills (no allocate).
- Conflict: load 0x104, then load 0x1104 (same index 0, different tag). Required:
  - Second load refills.
  - Reloading 0x104 misses again.
- Assert rst_n=0 during beat 2 of a refill. Required:
  - MemReq=0 and Stall=0 immediately.
  - After release, a load of the same address misses and restarts at beat 0.
- MemAck held high continuously during a refill. Required: 4 beats in 4 cycles, then RESPOND, then IDLE; no extra beat is issued.
